// File: rtl/de2i_150_qsys_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 30-bit packets of up to 15 codes and hands
// them out through a registered valid/ready slot with flush and drop accounting.
module de2i_150_qsys_nios2_qsys_oci_dct_packer #(
  parameter int unsigned OVF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dct_valid,
  input  logic [1:0]       dct_code,
  input  logic             flush,
  input  logic             pkt_ready,
  output logic [29:0]      dct_buffer,
  output logic [3:0]       dct_count,
  output logic             pkt_valid,
  output logic [29:0]      pkt_buffer,
  output logic [3:0]       pkt_count,
  output logic             overflow,
  output logic [OVF_W-1:0] ovf_count
);

  localparam int unsigned BUF_W    = 30;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_CODES = 15;

  logic [BUF_W-1:0] dct_buffer_q, dct_buffer_d;
  logic [CNT_W-1:0] dct_count_q,  dct_count_d;
  logic             pkt_valid_q,  pkt_valid_d;
  logic [BUF_W-1:0] pkt_buffer_q, pkt_buffer_d;
  logic [CNT_W-1:0] pkt_count_q,  pkt_count_d;
  logic             overflow_q,   overflow_d;
  logic [OVF_W-1:0] ovf_count_q,  ovf_count_d;
  logic             flush_pending_q, flush_pending_d;

  logic out_free_c;
  logic full_c;
  logic empty_c;
  logic load_c;

  always_comb begin
    out_free_c = !pkt_valid_q || pkt_ready;
    full_c     = (dct_count_q == CNT_W'(MAX_CODES));
    empty_c    = (dct_count_q == '0);
    load_c     = out_free_c && (full_c || ((flush || flush_pending_q) && !empty_c));
  end

  // Next-state: load has priority; otherwise drain the slot and append or drop.
  always_comb begin
    dct_buffer_d    = dct_buffer_q;
    dct_count_d     = dct_count_q;
    pkt_valid_d     = pkt_valid_q;
    pkt_buffer_d    = pkt_buffer_q;
    pkt_count_d     = pkt_count_q;
    overflow_d      = overflow_q;
    ovf_count_d     = ovf_count_q;
    flush_pending_d = flush_pending_q;

    if (load_c) begin
      pkt_buffer_d    = dct_buffer_q;
      pkt_count_d     = dct_count_q;
      pkt_valid_d     = 1'b1;
      flush_pending_d = 1'b0;
      // A code arriving with the load starts the next packet so nothing is lost.
      if (dct_valid) begin
        dct_buffer_d = {(BUF_W-2)'(0), dct_code};
        dct_count_d  = CNT_W'(1);
      end else begin
        dct_buffer_d = '0;
        dct_count_d  = '0;
      end
    end else begin
      if (pkt_valid_q && pkt_ready) begin
        pkt_valid_d = 1'b0;
      end
      if (flush && !empty_c) begin
        flush_pending_d = 1'b1;
      end
      if (dct_valid) begin
        if (!full_c) begin
          dct_buffer_d = {dct_buffer_q[BUF_W-3:0], dct_code};
          dct_count_d  = dct_count_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
          if (ovf_count_q != '1) begin
            ovf_count_d = ovf_count_q + OVF_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer_q    <= '0;
      dct_count_q     <= '0;
      pkt_valid_q     <= 1'b0;
      pkt_buffer_q    <= '0;
      pkt_count_q     <= '0;
      overflow_q      <= 1'b0;
      ovf_count_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      dct_buffer_q    <= dct_buffer_d;
      dct_count_q     <= dct_count_d;
      pkt_valid_q     <= pkt_valid_d;
      pkt_buffer_q    <= pkt_buffer_d;
      pkt_count_q     <= pkt_count_d;
      overflow_q      <= overflow_d;
      ovf_count_q     <= ovf_count_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign dct_buffer = dct_buffer_q;
  assign dct_count  = dct_count_q;
  assign pkt_valid  = pkt_valid_q;
  assign pkt_buffer = pkt_buffer_q;
  assign pkt_count  = pkt_count_q;
  assign overflow   = overflow_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_de2i_150_qsys_nios2_qsys_oci_dct_packer.sv
// Directed bench for the DCT packer: vector table plus hand sequences for
// fill, hold/overflow, flush-while-busy, async reset and counter saturation.
module tb_de2i_150_qsys_nios2_qsys_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        flush;
  logic        pkt_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic [29:0] pkt_buffer;
  logic [3:0]  pkt_count;
  logic        overflow;
  logic [7:0]  ovf_count;

  int n_checks = 0;
  int n_errors = 0;

  de2i_150_qsys_nios2_qsys_oci_dct_packer #(.OVF_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .dct_valid  (dct_valid),
    .dct_code   (dct_code),
    .flush      (flush),
    .pkt_ready  (pkt_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .pkt_valid  (pkt_valid),
    .pkt_buffer (pkt_buffer),
    .pkt_count  (pkt_count),
    .overflow   (overflow),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [1:0]  code;
    logic        fl;
    logic        rdy;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        e_pv;
    logic [3:0]  e_pcnt;
    logic [29:0] e_pbuf;
    logic        e_ovf;
    logic [7:0]  e_ovfc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] cnt, input logic [29:0] buff,
                           input logic pv, input logic [3:0] pc, input logic [29:0] pb,
                           input logic ov, input logic [7:0] ovc);
    check({tag, " dct_count"},  32'(dct_count),  32'(cnt));
    check({tag, " dct_buffer"}, 32'(dct_buffer), 32'(buff));
    check({tag, " pkt_valid"},  32'(pkt_valid),  32'(pv));
    check({tag, " pkt_count"},  32'(pkt_count),  32'(pc));
    check({tag, " pkt_buffer"}, 32'(pkt_buffer), 32'(pb));
    check({tag, " overflow"},   32'(overflow),   32'(ov));
    check({tag, " ovf_count"},  32'(ovf_count),  32'(ovc));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic step(input logic dv, input logic [1:0] code, input logic fl, input logic rdy);
    dct_valid = dv;
    dct_code  = code;
    flush     = fl;
    pkt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].dv, vecs[i].code, vecs[i].fl, vecs[i].rdy);
      check_all($sformatf("row%0d", i), vecs[i].e_cnt, vecs[i].e_buf, vecs[i].e_pv,
                vecs[i].e_pcnt, vecs[i].e_pbuf, vecs[i].e_ovf, vecs[i].e_ovfc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] exp_buf;

    // Codes 3,2,1 then flush; empty flush ignored.
    vecs[0]  = '{1, 2'd3, 0, 1, 4'd1, 30'h3,  0, 4'd15, 30'h15555555, 0, 8'd0};
    vecs[1]  = '{1, 2'd2, 0, 1, 4'd2, 30'hE,  0, 4'd15, 30'h15555555, 0, 8'd0};
    vecs[2]  = '{1, 2'd1, 0, 1, 4'd3, 30'h39, 0, 4'd15, 30'h15555555, 0, 8'd0};
    vecs[3]  = '{0, 2'd0, 1, 1, 4'd0, 30'h0,  1, 4'd3,  30'h39,       0, 8'd0};
    vecs[4]  = '{0, 2'd0, 1, 1, 4'd0, 30'h0,  0, 4'd3,  30'h39,       0, 8'd0};
    vecs[5]  = '{0, 2'd0, 0, 1, 4'd0, 30'h0,  0, 4'd3,  30'h39,       0, 8'd0};
    // Code arrives during the full-buffer load cycle.
    vecs[6]  = '{1, 2'd2, 0, 1, 4'd1, 30'h2,  1, 4'd15, 30'h3FFFFFFF, 1, 8'd4};
    // Flush while slot busy, more codes, then ready.
    vecs[7]  = '{1, 2'd1, 1, 0, 4'd2, 30'h9,  1, 4'd15, 30'h3FFFFFFF, 1, 8'd4};
    vecs[8]  = '{1, 2'd3, 0, 0, 4'd3, 30'h27, 1, 4'd15, 30'h3FFFFFFF, 1, 8'd4};
    vecs[9]  = '{1, 2'd0, 0, 0, 4'd4, 30'h9C, 1, 4'd15, 30'h3FFFFFFF, 1, 8'd4};
    vecs[10] = '{0, 2'd0, 0, 1, 4'd0, 30'h0,  1, 4'd4,  30'h9C,       1, 8'd4};
    vecs[11] = '{0, 2'd0, 0, 1, 4'd0, 30'h0,  0, 4'd4,  30'h9C,       1, 8'd4};
    vecs[12] = '{0, 2'd0, 0, 1, 4'd0, 30'h0,  0, 4'd4,  30'h9C,       1, 8'd4};
    vecs[13] = '{0, 2'd0, 0, 0, 4'd0, 30'h0,  0, 4'd4,  30'h9C,       1, 8'd4};
    vecs[14] = '{0, 2'd0, 1, 1, 4'd0, 30'h0,  0, 4'd4,  30'h9C,       1, 8'd4};

    reset = 1'b1; dct_valid = 0; dct_code = 0; flush = 0; pkt_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'd0, 30'h0, 0, 4'd0, 30'h0, 0, 8'd0);
    reset = 1'b0;

    // Fill with 15 codes of 01, ready high.
    exp_buf = '0;
    for (int i = 0; i < 15; i++) begin
      step(1, 2'd1, 0, 1);
      exp_buf = (exp_buf << 2) | 30'd1;
      check($sformatf("fill1 count%0d", i), 32'(dct_count), 32'(i + 1));
      check($sformatf("fill1 buf%0d", i), 32'(dct_buffer), 32'(exp_buf));
    end
    check("fill1 no early pkt", 32'(pkt_valid), 32'd0);
    step(0, 2'd0, 0, 1);
    check_all("full pkt", 4'd0, 30'h0, 1, 4'd15, 30'h15555555, 0, 8'd0);

    run_rows(0, 5);

    // Ready low: fill with code 2, load into free slot, then hold it.
    exp_buf = '0;
    for (int i = 0; i < 15; i++) begin
      step(1, 2'd2, 0, 0);
      exp_buf = (exp_buf << 2) | 30'd2;
    end
    check("fill2 count", 32'(dct_count), 32'd15);
    check("fill2 buf", 32'(dct_buffer), 32'h2AAAAAAA);
    step(0, 2'd0, 0, 0);
    check_all("held pkt", 4'd0, 30'h0, 1, 4'd15, 30'h2AAAAAAA, 0, 8'd0);
    exp_buf = '0;
    for (int i = 0; i < 15; i++) begin
      step(1, 2'd3, 0, 0);
      exp_buf = (exp_buf << 2) | 30'd3;
      check_all($sformatf("fill3 c%0d", i), 4'(i + 1), exp_buf, 1, 4'd15, 30'h2AAAAAAA, 0, 8'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 2'd1, 0, 0);
      check_all($sformatf("drop%0d", i), 4'd15, 30'h3FFFFFFF, 1, 4'd15, 30'h2AAAAAAA,
                1, 8'(i + 1));
    end

    run_rows(6, 14);

    // Build count=7 with a held packet, then assert reset between edges.
    for (int i = 0; i < 15; i++) step(1, 2'd1, 0, 0);
    step(0, 2'd0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2'd2, 0, 0);
    check("pre-reset count", 32'(dct_count), 32'd7);
    check("pre-reset pkt_valid", 32'(pkt_valid), 32'd1);
    check("pre-reset ovf_count", 32'(ovf_count), 32'd4);
    dct_valid = 0;
    #1 reset = 1'b1;
    #1;
    check_all("async reset", 4'd0, 30'h0, 0, 4'd0, 30'h0, 0, 8'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Force 300 drops; counter must saturate at 255.
    for (int i = 0; i < 15; i++) step(1, 2'd1, 0, 0);
    step(0, 2'd0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 2'd1, 0, 0);
    check("sat pre overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      step(1, 2'd0, 0, 0);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check($sformatf("sat ovf_count@%0d", i), 32'(ovf_count), 32'((i > 255) ? 255 : i));
    end
    check("sat overflow", 32'(overflow), 32'd1);
    check("sat pkt stable", 32'(pkt_buffer), 32'h15555555);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
